// File: rtl/io_mem_arbiter.sv
// io_mem_arbiter: round-robin arbiter for data-memory port B, one word transaction per grant.
// Optional macro IO_ARB_BOUNDS_EN rejects accesses outside DEPTH_WORDS and flags them on ch_err.
module io_mem_arbiter #(
    parameter int unsigned           NUM_CH       = 4,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned           DEPTH_WORDS  = 16384,
    parameter int unsigned           READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0]                ch_wren,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]                ch_ack,
    output logic                             ch_err,
    output logic [DATA_WIDTH-1:0]            ch_rdata,
    output logic [$clog2(NUM_CH)-1:0]        grant_id,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_wren,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);
    localparam int unsigned GW = $clog2(NUM_CH);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("io_mem_arbiter: NUM_CH must be 2..16");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("io_mem_arbiter: READ_LATENCY must be 1..4");
    end
    if (DEPTH_WORDS == 0) begin : g_bad_depth
        $error("io_mem_arbiter: DEPTH_WORDS must be non-zero");
    end

    state_t                state, state_next;
    logic [GW-1:0]         ptr;
    logic [GW-1:0]         sel;
    logic [GW-1:0]         idx;
    logic                  found;
    logic                  wren_q;
    logic [CW-1:0]         cnt;
    logic                  wait_last;
    logic                  reject;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_off;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wren;
    logic [NUM_CH-1:0]     one_hot_base;

    assign one_hot_base = {{(NUM_CH-1){1'b0}}, 1'b1};
    assign sel_addr     = ch_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata    = ch_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
    assign sel_wren     = ch_wren[sel];
    assign sel_off      = sel_addr - BASE_ADDR;
    assign wait_last    = (cnt == CW'(READ_LATENCY - 1));

`ifdef IO_ARB_BOUNDS_EN
    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] LIMIT = LW'(DEPTH_WORDS) << 2;

    assign reject = ({1'b0, sel_off} >= LIMIT);

    // Error flag rides along with the ack of a rejected access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_err <= 1'b0;
        end else begin
            ch_err <= (state == ST_IDLE) && found && reject;
        end
    end
`else
    assign reject = 1'b0;
    assign ch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin search starting at ptr, plus next-state decode.
    always_comb begin
        state_next = state;
        found      = 1'b0;
        sel        = '0;
        idx        = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            idx = GW'((int'(ptr) + i) % int'(NUM_CH));
            if (!found && ch_req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        case (state)
            ST_IDLE:  if (found) state_next = reject ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_next = wren_q ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (wait_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered datapath: grant latch, memory drive, ack/rdata generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            grant_id  <= '0;
            wren_q    <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            ch_ack    <= '0;
            ch_rdata  <= '0;
            mem_addr  <= '0;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
        end else begin
            ch_ack   <= '0;
            mem_wren <= 1'b0;
            busy     <= (state_next != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id  <= sel;
                        wren_q    <= sel_wren;
                        mem_addr  <= sel_off >> 2;
                        mem_wdata <= sel_wdata;
                        if (reject) begin
                            ch_ack   <= one_hot_base << sel;
                            ch_rdata <= '0;
                        end else begin
                            mem_wren <= sel_wren;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                    if (wren_q) ch_ack <= one_hot_base << grant_id;
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (wait_last) begin
                        ch_rdata <= mem_rdata;
                        ch_ack   <= one_hot_base << grant_id;
                    end
                end
                ST_DONE: begin
                    ptr <= GW'((int'(grant_id) + 1) % int'(NUM_CH));
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_io_mem_arbiter.sv
// Self-checking bench for io_mem_arbiter: directed vector table plus multi-cycle sequences.
// Define IO_ARB_BOUNDS_EN for both files to exercise the range-rejection path.
module tb_io_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   wren;
    logic [127:0] addr_bus;
    logic [127:0] wdata_bus;
    logic [3:0]   ch_ack;
    logic         ch_err;
    logic [31:0]  ch_rdata;
    logic [1:0]   grant_id;
    logic         busy;
    logic [31:0]  mem_addr;
    logic         mem_wren;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    logic [31:0]  ram [0:63];
    int           tests = 0;
    int           fails = 0;

    io_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (req),
        .ch_wren   (wren),
        .ch_addr   (addr_bus),
        .ch_wdata  (wdata_bus),
        .ch_ack    (ch_ack),
        .ch_err    (ch_err),
        .ch_rdata  (ch_rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Port-B RAM model: registered address, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr[5:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[5:0]];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-requester transaction with timing, data and handshake checks.
    task automatic run_txn(input string tag, input int ch, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] maddr,
                           input logic [31:0] rdata, input int lat, input bit err);
        int cyc;
        int pulses;
        bit ackd;
        @(negedge clk);
        wren[ch]             = wr;
        addr_bus[ch*32 +: 32]  = addr;
        wdata_bus[ch*32 +: 32] = wdata;
        req[ch]              = 1'b1;
        cyc    = 0;
        pulses = 0;
        ackd   = 1'b0;
        while (!ackd && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (cyc == 1 && lat > 1) check({tag, "_mem_addr"}, mem_addr, maddr);
            if (mem_wren) begin
                pulses++;
                check({tag, "_mem_wdata"}, mem_wdata, wdata);
            end
            if (ch_ack != '0) ackd = 1'b1;
        end
        req[ch] = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_ack"}, 32'(ch_ack), 32'(4'b0001 << ch));
        check({tag, "_rdata"}, ch_rdata, rdata);
        check({tag, "_err"}, 32'(ch_err), 32'(err));
        check({tag, "_wren_pulses"}, 32'(pulses), (wr && !err) ? 32'd1 : 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'(ch));
    endtask

    initial begin
        int got [8];
        int hold [4];
        int n;
        int cyc;
        int stray;

        vecs[0] = '{2, 1'b0, 32'h1000_0010, 32'h0000_0000, 32'd4,  32'h1234_5678, 3};
        vecs[1] = '{0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'd4,  32'h1234_5678, 2};
        vecs[2] = '{1, 1'b0, 32'h1000_0010, 32'h0000_0000, 32'd4,  32'hDEAD_BEEF, 3};
        vecs[3] = '{3, 1'b1, 32'h1000_0023, 32'hA5A5_0001, 32'd8,  32'hDEAD_BEEF, 2};
        vecs[4] = '{0, 1'b0, 32'h1000_0020, 32'h0000_0000, 32'd8,  32'hA5A5_0001, 3};
        vecs[5] = '{2, 1'b1, 32'h1000_003C, 32'h0BAD_F00D, 32'd15, 32'hA5A5_0001, 2};
        vecs[6] = '{3, 1'b0, 32'h1000_003F, 32'h0000_0000, 32'd15, 32'h0BAD_F00D, 3};

        for (int i = 0; i < 64; i++) ram[i] = 32'h0000_0100 + 32'(i);
        ram[0]  = 32'h5A5A_0000;
        ram[4]  = 32'h1234_5678;
        ram[63] = 32'hCAFE_0063;

        rst       = 1'b1;
        req       = '0;
        wren      = '0;
        addr_bus  = {4{32'h1000_0000}};
        wdata_bus = '0;
        repeat (3) @(negedge clk);

        check("rst_ack",       32'(ch_ack),   32'd0);
        check("rst_err",       32'(ch_err),   32'd0);
        check("rst_rdata",     ch_rdata,      32'd0);
        check("rst_grant_id",  32'(grant_id), 32'd0);
        check("rst_busy",      32'(busy),     32'd0);
        check("rst_mem_addr",  mem_addr,      32'd0);
        check("rst_mem_wren",  32'(mem_wren), 32'd0);
        check("rst_mem_wdata", mem_wdata,     32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_txn($sformatf("v%0d", k), vecs[k].ch, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                    vecs[k].maddr, vecs[k].rdata, vecs[k].lat, 1'b0);
        end

        // All four request together after reset; ch0 re-requests once ch1 is served.
        do_reset();
        for (int i = 0; i < 4; i++) addr_bus[i*32 +: 32] = 32'h1000_0080 + 32'(4 * i);
        wren = 4'hF;
        @(negedge clk);
        req = 4'hF;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ch_ack != '0) begin
                check($sformatf("t3_onehot%0d", n), 32'($countones(ch_ack)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (ch_ack[i]) begin
                        got[n] = i;
                        req[i] = 1'b0;
                        if (i == 1) req[0] = 1'b1;
                    end
                end
                n++;
            end
        end
        req = '0;
        check("t3_ack_count", 32'(n), 32'd5);
        check("t3_order0", 32'(got[0]), 32'd0);
        check("t3_order1", 32'(got[1]), 32'd1);
        check("t3_order2", 32'(got[2]), 32'd2);
        check("t3_order3", 32'(got[3]), 32'd3);
        check("t3_order4", 32'(got[4]), 32'd0);
        repeat (4) @(negedge clk);

        // Ch1 (read) and ch3 (write) re-request as soon as the handshake allows.
        addr_bus[1*32 +: 32] = 32'h1000_0000;
        wren = 4'b1000;
        hold = '{0, 0, 0, 0};
        @(negedge clk);
        req = 4'b1010;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) req[i] = 1'b1;
                end
            end
            if (ch_ack != '0) begin
                check($sformatf("t4_onehot%0d", n), 32'($countones(ch_ack)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (ch_ack[i]) begin
                        got[n]  = i;
                        req[i]  = 1'b0;
                        hold[i] = 2;
                    end
                end
                n++;
            end
        end
        req = '0;
        check("t4_ack_count", 32'(n), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t4_order%0d", k), 32'(got[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
        end
        repeat (10) @(negedge clk);

        // Reset in the WAIT cycle of a read; pointer left at 3 beforehand.
        run_txn("t5_pre", 2, 1'b1, 32'h1000_0040, 32'h1111_2222, 32'd16, 32'h5A5A_0000, 2, 1'b0);
        @(negedge clk);
        wren[2] = 1'b0;
        addr_bus[2*32 +: 32] = 32'h1000_0010;
        req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_busy_drop", 32'(busy), 32'd0);
        check("t5_ack_drop", 32'(ch_ack), 32'd0);
        check("t5_wren_drop", 32'(mem_wren), 32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (ch_ack != '0 || busy) stray++;
        end
        check("t5_no_stale_ack", 32'(stray), 32'd0);
        check("t5_grant_id", 32'(grant_id), 32'd0);
        addr_bus[0*32 +: 32] = 32'h1000_0000;
        addr_bus[3*32 +: 32] = 32'h1000_0000;
        wren = '0;
        req = 4'b1001;
        n = 0;
        cyc = 0;
        while (n < 1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ch_ack != '0) begin
                got[0] = 32'(ch_ack);
                req = '0;
                n++;
            end
        end
        req = '0;
        check("t5_first_after_reset", 32'(got[0]), 32'b0001);
        repeat (4) @(negedge clk);

`ifdef IO_ARB_BOUNDS_EN
        run_txn("t6_rd_below", 1, 1'b0, 32'h0FFF_FFFC, 32'h0,         32'h0, 32'h0, 1, 1'b1);
        run_txn("t6_wr_above", 3, 1'b1, 32'h1001_0000, 32'h7777_7777, 32'h0, 32'h0, 1, 1'b1);
        run_txn("t6_last_ok",  2, 1'b1, 32'h1000_FFFC, 32'h4444_5555, 32'h0000_3FFF, 32'h0, 2, 1'b0);
`else
        run_txn("t6_wrap", 1, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'h3FFF_FFFF, 32'hCAFE_0063, 3, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
